// File: rtl/mod461_pkg.sv
// Shared constants, FSM state type and constant helpers for the mod-461
// residue datapath.
package mod461_pkg;

   localparam int unsigned MOD        = 461;
   localparam int unsigned CHUNK_W    = 6;
   localparam int unsigned RES_W      = 9;
   localparam int unsigned POS_W      = 4;
   localparam int unsigned MAX_CHUNKS = 16;

   // Modulus at the width of an unreduced sum of two residues.
   localparam logic [RES_W:0] MOD_SUM = 10'd461;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // 2^k mod 461 by repeated doubling; only evaluated at elaboration time
   // to build the per-position chunk weights.
   function automatic logic [RES_W-1:0] pow2_mod(input int unsigned k);
      logic [RES_W:0] r;
      r = 10'd1;
      for (int unsigned i = 0; i < k; i++) begin
         r = r << 1;
         if (r >= MOD_SUM) begin
            r = r - MOD_SUM;
         end
      end
      return r[RES_W-1:0];
   endfunction

   // Modular add of two values already in 0..460: the raw sum is at most
   // 920, so one conditional subtract is enough.
   function automatic logic [RES_W-1:0] mod_add(input logic [RES_W-1:0] a,
                                                input logic [RES_W-1:0] b);
      logic [RES_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= MOD_SUM) begin
         s = s - MOD_SUM;
      end
      return s[RES_W-1:0];
   endfunction

endpackage

// File: rtl/mod461_chunk_lut.sv
// Combinational chunk-weight table: res = (chunk * 2^(6*pos)) mod 461.
// Each position is a constant-weight multiply/reduce of a 6-bit input, so a
// synthesizer can collapse every position into a small 6-input LUT block.
module mod461_chunk_lut
   import mod461_pkg::*;
(
   input  logic [POS_W-1:0]   pos,
   input  logic [CHUNK_W-1:0] chunk,
   output logic [RES_W-1:0]   res
);

   // 63 * 460 = 28980 fits in 15 bits.
   localparam int unsigned PROD_W = 15;

   logic [RES_W-1:0] res_pos [MAX_CHUNKS];

   for (genvar p = 0; p < MAX_CHUNKS; p++) begin : g_pos
      localparam logic [RES_W-1:0]  WEIGHT   = pow2_mod(CHUNK_W * p);
      localparam logic [PROD_W-1:0] WEIGHT_W = {{(PROD_W-RES_W){1'b0}}, WEIGHT};
      localparam logic [PROD_W-1:0] MOD_W    = 15'd461;

      logic [PROD_W-1:0] prod;
      logic [PROD_W-1:0] rem;

      assign prod       = {{(PROD_W-CHUNK_W){1'b0}}, chunk} * WEIGHT_W;
      assign rem        = prod % MOD_W;
      assign res_pos[p] = rem[RES_W-1:0];
   end

   assign res = res_pos[pos];

endmodule

// File: rtl/mod461_serial_reducer.sv
// Serial mod-461 reducer: captures a 6*NCHUNK-bit operand, walks it one
// 6-bit chunk per cycle (LSB first) through a shared weight table, and
// accumulates the chunk residues with a modular adder. The result is
// offered on a valid/ready port; a new operand is only taken in IDLE.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// RUN   | one chunk folded into acc per cycle, idx = chunk position
// DONE  | out_valid high, out_residue = acc held until out_ready
module mod461_serial_reducer
   import mod461_pkg::*;
#(
   parameter int unsigned NCHUNK = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CHUNK_W*NCHUNK-1:0] in_operand,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [RES_W-1:0]          out_residue,
   output logic                      busy
);

   localparam int unsigned      OP_W     = CHUNK_W * NCHUNK;
   localparam logic [POS_W-1:0] LAST_IDX = POS_W'(NCHUNK - 1);

   state_e           state;
   state_e           state_nxt;
   logic [OP_W-1:0]  operand_q;
   logic [RES_W-1:0] acc;
   logic [POS_W-1:0] idx;
   logic [RES_W-1:0] lut_res;
   logic             accept;
   logic             last_chunk;

   // The operand register shifts right each RUN cycle, so the current chunk
   // is always the low bits; idx only selects the weight.
   mod461_chunk_lut u_lut (
      .pos   (idx),
      .chunk (operand_q[CHUNK_W-1:0]),
      .res   (lut_res)
   );

   assign accept      = in_valid & in_ready;
   assign last_chunk  = (idx == LAST_IDX);
   assign out_residue = acc;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs, all decoded from the current state.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_chunk) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture and per-chunk accumulate; acc stays in 0..460 because
   // both addends are reduced residues.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         operand_q <= '0;
         acc       <= '0;
         idx       <= '0;
      end else if (accept) begin
         operand_q <= in_operand;
         acc       <= '0;
         idx       <= '0;
      end else if (state == RUN) begin
         operand_q <= operand_q >> CHUNK_W;
         acc       <= mod_add(acc, lut_res);
         idx       <= idx + POS_W'(1);
      end
   end

endmodule

// File: tb/tb_mod461_serial_reducer.sv
// Bench for mod461_serial_reducer: table of directed operands, hand-written
// latency / backpressure / reset sequences, and a random stream, all checked
// through an in-order scoreboard of expected residues.
module tb_mod461_serial_reducer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [47:0] in_operand;
   logic        out_valid;
   logic        out_ready;
   logic [8:0]  out_residue;
   logic        busy;

   int          n_cmp;
   int          n_err;
   int          n_pop;
   logic [8:0]  exp_cur;
   logic [8:0]  sb [$];

   typedef struct {
      logic [47:0] op;
      logic [8:0]  exp;
   } vec_t;

   vec_t vecs [8];

   mod461_serial_reducer #(.NCHUNK(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_operand  (in_operand),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_residue (out_residue),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Push on accepted operand, pop and compare on completed result.
   always @(negedge clk) begin : sb_mon
      logic [8:0] want;
      if (rst_n && in_valid && in_ready) begin
         sb.push_back(exp_cur);
      end
      if (rst_n && out_valid && out_ready) begin
         n_pop++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: got residue %0d with nothing outstanding", out_residue);
         end else begin
            want = sb.pop_front();
            chk("residue", 64'(out_residue), 64'(want));
         end
      end
   end

   // Called #1 after a posedge; returns #1 after the acceptance edge.
   task automatic send(input logic [47:0] op, input logic [8:0] exp);
      int   cyc;
      logic took;
      cyc        = 0;
      took       = 1'b0;
      in_operand = op;
      exp_cur    = exp;
      in_valid   = 1'b1;
      while (!took && cyc < 100) begin
         @(negedge clk);
         if (in_ready) took = 1'b1;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      if (!took) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: got no acceptance of %0d expected acceptance", op);
      end
   endtask

   task automatic wait_drain(input string nm);
      int cyc;
      cyc = 0;
      while ((sb.size() != 0 || out_valid) && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk(nm, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int          edges;
      int          cyc;
      int          sent;
      int          pops0;
      logic        took;
      logic [63:0] r;
      logic [47:0] rem;

      n_cmp      = 0;
      n_err      = 0;
      n_pop      = 0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_operand = '0;
      out_ready  = 1'b0;
      exp_cur    = '0;

      vecs[0] = '{48'd0,              9'd0};
      vecs[1] = '{48'd460,            9'd460};
      vecs[2] = '{48'd461,            9'd0};
      vecs[3] = '{48'd927,            9'd5};
      vecs[4] = '{48'd64,             9'd64};
      vecs[5] = '{48'd4096,           9'd408};
      vecs[6] = '{48'd262144,         9'd296};
      vecs[7] = '{48'hFFFF_FFFF_FFFF, 9'd4};

      // Reset state.
      #2;
      chk("rst_out_valid",   64'(out_valid),   64'd0);
      chk("rst_in_ready",    64'(in_ready),    64'd1);
      chk("rst_busy",        64'(busy),        64'd0);
      chk("rst_out_residue", 64'(out_residue), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency for operand 0: out_valid after 9 edges from presenting it.
      in_operand = '0;
      exp_cur    = 9'd0;
      in_valid   = 1'b1;
      edges      = 0;
      while (!out_valid && edges < 30) begin
         @(posedge clk);
         #1;
         edges++;
         if (edges == 1) in_valid = 1'b0;
         if (edges == 4) begin
            chk("run_in_ready", 64'(in_ready), 64'd0);
            chk("run_busy",     64'(busy),     64'd1);
         end
      end
      chk("latency_edges",     64'(edges),    64'd9);
      chk("done_in_ready",     64'(in_ready), 64'd0);
      out_ready = 1'b1;
      wait_drain("latency_drain");

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].op, vecs[i].exp);
         wait_drain("table_drain");
      end

      // Backpressure, plus in_valid pulses during RUN and DONE.
      out_ready = 1'b0;
      send(48'd927, 9'd5);
      in_operand = 48'd460;
      exp_cur    = 9'd460;
      in_valid   = 1'b1;
      chk("bp_run_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 30) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("bp_out_valid_rise", 64'(out_valid), 64'd1);
      in_operand = 48'd64;
      exp_cur    = 9'd64;
      in_valid   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_valid",    64'(out_valid),   64'd1);
         chk("bp_hold_residue",  64'(out_residue), 64'd5);
         chk("bp_done_in_ready", 64'(in_ready),    64'd0);
      end
      out_ready = 1'b1;
      send(48'd64, 9'd64);
      wait_drain("bp_drain");

      // Reset during RUN at idx 3.
      send(48'd64, 9'd64);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
      chk("mid_rst_busy",      64'(busy),      64'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(48'd461, 9'd0);
      wait_drain("post_rst_drain");

      // Random stream with random out_ready.
      sent  = 0;
      cyc   = 0;
      pops0 = n_pop;
      while ((sent < 1000 || sb.size() != 0 || out_valid) && cyc < 40000) begin
         out_ready = 1'($urandom_range(0, 1));
         if (!in_valid && sent < 1000) begin
            r          = {$urandom, $urandom};
            in_operand = r[47:0];
            rem        = r[47:0] % 48'd461;
            exp_cur    = rem[8:0];
            in_valid   = 1'b1;
         end
         @(negedge clk);
         took = in_valid && in_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (took) begin
            in_valid = 1'b0;
            sent++;
         end
      end
      chk("rand_sent",     64'(sent),          64'd1000);
      chk("rand_results",  64'(n_pop - pops0), 64'd1000);
      chk("rand_sb_empty", 64'(sb.size()),     64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
